// File: rtl/mean_pack32.sv
// mean_pack32: packs the 8-bit filtered pixel stream into 32-bit words behind a ready/valid FIFO.
// Define MEAN_PACK_HDR_EN to emit a {8'hA5, 8'h00, frame_cnt} header word at the start of each frame.
module mean_pack32 #(
    parameter int FRAME_PIXELS = 75684,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        overflow
);
    localparam int CW = $clog2(FRAME_PIXELS);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0] pcnt;
    logic [1:0]    idx;
    logic [23:0]   pend;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [3:0]    mem_keep [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic          last_pix, hdr, pix_push, push, pop, accept, push_last;
    logic [31:0]   pix_word, push_data;
    logic [4:0]    keep_ext;
    logic [3:0]    push_keep;

    always_comb begin
        last_pix  = pix_valid && pcnt == CW'(FRAME_PIXELS - 1);
`ifdef MEAN_PACK_HDR_EN
        hdr       = pix_valid && pcnt == '0;
`else
        hdr       = 1'b0;
`endif
        // Pending lanes above idx are always zero, so OR-ing in the new byte also zero-pads.
        pix_word  = {8'h00, pend} | ({24'h0, pix_data} << {idx, 3'b000});
        keep_ext  = (5'd2 << idx) - 5'd1;
        pix_push  = pix_valid && (idx == 2'd3 || last_pix);
        // FRAME_PIXELS >= 2 guarantees the header and a pixel word never collide.
        push      = hdr || pix_push;
        push_data = hdr ? {8'hA5, 8'h00, frame_cnt} : pix_word;
        push_keep = hdr ? 4'hF : keep_ext[3:0];
        push_last = !hdr && last_pix;
        pop       = m_valid && m_ready;
        accept    = push && (count != (AW+1)'(FIFO_DEPTH) || pop);
    end

    assign m_valid    = count != '0;
    assign m_data     = m_valid ? mem_data[rd_ptr] : '0;
    assign m_keep     = m_valid ? mem_keep[rd_ptr] : '0;
    assign m_last     = m_valid ? mem_last[rd_ptr] : 1'b0;
    assign frame_done = last_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            idx       <= '0;
            pend      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pix_valid) begin
                pcnt <= last_pix ? '0 : pcnt + CW'(1);
                idx  <= pix_push ? 2'd0 : idx + 2'd1;
                pend <= pix_push ? 24'h0 : pix_word[23:0];
            end
            frame_cnt <= frame_cnt + 16'(last_pix);
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (push && !accept) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr] <= push_data;
            mem_keep[wr_ptr] <= push_keep;
            mem_last[wr_ptr] <= push_last;
        end
    end
endmodule

// File: tb/tb_mean_pack32.sv
// tb_mean_pack32: directed scoreboard bench for mean_pack32 with a 6-pixel frame and a 4-word FIFO.
// Honors MEAN_PACK_HDR_EN when it is defined for the build.
module tb_mean_pack32;
    localparam int FP = 6;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        overflow;

    int errs = 0;
    int checks = 0;

    logic [31:0] mw;
    logic [3:0]  mk;
    int          midx, mpcnt;
    logic [15:0] mfc;
    logic        movf;
    logic [36:0] q[$];

    mean_pack32 #(.FRAME_PIXELS(FP), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
        .m_last(m_last), .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mw = '0;
        mk = '0;
        midx = 0;
        mpcnt = 0;
        mfc = '0;
        movf = 1'b0;
    endtask

    // One clock of stimulus; the model predicts the push and pop of this cycle and the DUT is checked at the negedge.
    task automatic step(input logic pv, input logic [7:0] pd, input logic rdy);
        logic [36:0] pw;
        logic pu, lp, popping;
        pix_valid = pv;
        pix_data  = pd;
        m_ready   = rdy;
        @(negedge clk);
        chk("overflow", overflow, movf);
        chk("frame_cnt", frame_cnt, mfc);
        chk("m_valid", m_valid, q.size() != 0);
        pu = 1'b0;
        pw = '0;
        lp = pv && mpcnt == FP - 1;
`ifdef MEAN_PACK_HDR_EN
        if (pv && mpcnt == 0) begin
            pu = 1'b1;
            pw = {8'hA5, 8'h00, mfc, 4'hF, 1'b0};
        end
`endif
        chk("frame_done", frame_done, lp);
        if (pv) begin
            mw[8*midx +: 8] = pd;
            mk[midx] = 1'b1;
            if (midx == 3 || lp) begin
                pu = 1'b1;
                pw = {mw, mk, lp};
                mw = '0;
                mk = '0;
                midx = 0;
            end else midx++;
            if (lp) begin
                mpcnt = 0;
                mfc++;
            end else mpcnt++;
        end
        popping = rdy && q.size() != 0;
        if (popping) begin
            chk("head", {m_data, m_keep, m_last}, q[0]);
            void'(q.pop_front());
        end
        if (pu) begin
            if (q.size() < D) q.push_back(pw);
            else movf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        m_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Four pixels then finish frame 0 with a two-byte word.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h05, 1'b1);
        step(1'b1, 8'h06, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // Whole frame 0x10..0x15.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("t2_frame_cnt", frame_cnt, 16'd2);
        // Fill the FIFO, then stream with a pop on every cycle including pushes while full.
        for (int j = 0; j < 100 && q.size() < D; j++) step(1'b1, 8'($urandom), 1'b0);
        chk("fill_m_valid", m_valid, 1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b1);
        repeat (8) step(1'b0, 8'h00, 1'b1);
        chk("full_pop_no_ovf", overflow, 0);
        // Overrun the FIFO with m_ready low, then drain.
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0);
        chk("ovf_set", overflow, 1);
        repeat (6) step(1'b0, 8'h00, 1'b1);
        // Async reset mid-word with a non-empty FIFO.
        for (int j = 0; j < 100 && (midx != 2 || q.size() == 0); j++) step(1'b1, 8'($urandom), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        model_reset();
        pix_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hB1, 1'b1);
        step(1'b1, 8'hB2, 1'b1);
        // Two consecutive frames back to back.
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        repeat (5) step(1'b0, 8'h00, 1'b1);
        chk("end_frame_cnt", frame_cnt, 16'd3);
        chk("end_empty", m_valid, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mean_pack32.md
Name: mean_pack32

Overview:
- Downstream consumer of the 3x3 mean filter stage.
- Packs the 8-bit filtered pixel stream (valid-only, no backpressure) into 32-bit words.
- Buffers the words in a small FIFO and presents them on a ready/valid master interface toward the frame writer/DMA.
- Tracks frame boundaries by pixel count: flags the last word of each frame, pulses frame completion and reports FIFO overflow.

Parameters:
- FRAME_PIXELS, 75684, filtered pixels per frame (318x238); must be >= 2.
- FIFO_DEPTH, 16, word entries in the output FIFO; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  one filtered pixel present this cycle.
- pix_data  in  8  filtered pixel value.
- m_valid  out  1  FIFO head word available.
- m_ready  in  1  downstream accepts the head word.
- m_data  out  32  packed word; first pixel in [7:0], fourth in [31:24].
- m_keep  out  4  byte-valid mask of the head word.
- m_last  out  1  head word is the final word of a frame.
- frame_done  out  1  one-cycle pulse when a frame's final word is pushed into the FIFO.
- frame_cnt  out  16  completed frames; wraps 0xFFFF->0.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO empty; packer byte index 0; pixel counter 0; frame_cnt 0; overflow 0. Reset mid-frame discards any partial word and the FIFO contents.
- Packer:
  - Holds up to 3 pending bytes plus a byte index 0..3.
  - On pix_valid, the byte goes to lane [index].
  - The word is pushed when the 4th byte arrives, or when the pixel is the frame's last (pixel counter == FRAME_PIXELS-1).
  - A partial word is zero-padded; m_keep has bits set for lanes filled (e.g. 2 bytes -> 4'b0011); full word -> 4'hF.
  - After a push the byte index returns to 0.
- Pixel counter: increments on pix_valid and wraps to 0 after FRAME_PIXELS-1. On the final pixel, the pushed word carries last=1 and frame_done pulses in the same cycle as the push.
- frame_cnt: increments on the frame_done cycle, including when that word is dropped.
- FIFO:
  - m_valid = (count != 0). m_data/m_keep/m_last reflect the head entry.
  - Pop when m_valid && m_ready.
  - Push is accepted when count < FIFO_DEPTH, or when full with a pop in the same cycle (count unchanged, pointers both advance).
  - Push while full without a pop: the word is dropped and overflow is set to 1 until reset. Counters still advance, so framing stays aligned.
  - Latency: a pushed word appears on m_valid the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- m_ready while m_valid=0: ignored. Head outputs stay stable while m_valid=1 and m_ready=0.
- Throughput: at most one push per cycle; input never stalls.

Optional Feature:
- MEAN_PACK_HDR_EN defined:
  - On the first pixel of each frame (pixel counter == 0 with pix_valid), a header word {8'hA5, 8'h00, frame_cnt} is pushed that cycle, with m_keep=4'hF and m_last=0.
  - The first pixel is captured in lane 0 normally.
  - The header is subject to the same overflow rule.
- MEAN_PACK_HDR_EN undefined: no header word; the stream contains pixel words only.

Test Plan:
- Reset, then pixels 0x01,0x02,0x03,0x04 on consecutive cycles with m_ready=1 -> one word m_data=0x04030201, m_keep=4'hF, m_last=0, m_valid the cycle after the 4th pixel.
- FRAME_PIXELS=6, pixels 0x10..0x15 -> words 0x13121110/keep F/last 0, then 0x00001514/keep 4'b0011/last 1; frame_done pulses once; frame_cnt=1.
- FIFO_DEPTH=4, m_ready=0, push 5 words -> overflow=1 after the 5th push; then drain with m_ready=1 -> exactly the first 4 words in order.
- Full FIFO with m_ready=1 and a push in the same cycle -> no overflow; count stays 4; ordering preserved.
- Assert rst_n=0 mid-word after 2 pixels -> m_valid=0 and overflow=0 immediately (async); the next 4 pixels form a fresh word with the first in [7:0].
- With MEAN_PACK_HDR_EN, two 6-pixel frames -> 0xA5000000 precedes frame 0 and 0xA5000001 precedes frame 1; m_last is set only on each frame's final pixel word.
